// File: rtl/ari_rigs.sv
// Signed arithmetic right-shift register: load a word, then shift one bit per enabled edge, up to N steps.
// All outputs are registered and update one clock after the load/shift edge; no handshake, so every qualified edge is consumed.
module ari_rigs #(
    parameter int N = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load,
    input  logic                     shift_en,
    input  logic signed [N:0]        a,
    output logic signed [N:0]        b,
    output logic [$clog2(N+1)-1:0]   step,
    output logic                     shift_out,
    output logic                     done
);

    localparam int SW = $clog2(N+1);
    localparam logic [SW-1:0] LAST = SW'(N);

    logic signed [N:0] r_q, r_d;
    logic [SW-1:0]     s_q, s_d;
    logic [SW-1:0]     s_inc;
    logic              so_q, so_d;
    logic              done_q, done_d;

    assign s_inc = s_q + 1'b1;

    always_comb begin
        r_d    = r_q;
        s_d    = s_q;
        so_d   = so_q;
        done_d = done_q;
        if (load) begin
            r_d    = a;
            s_d    = '0;
            so_d   = 1'b0;
            done_d = 1'b0;
        end else if (shift_en && !done_q) begin
            // MSB replicated so the result is floor(R / 2)
            r_d    = {r_q[N], r_q[N:1]};
            so_d   = r_q[0];
            s_d    = s_inc;
            done_d = (s_inc == LAST);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q    <= '0;
            s_q    <= '0;
            so_q   <= 1'b0;
            done_q <= 1'b0;
        end else begin
            r_q    <= r_d;
            s_q    <= s_d;
            so_q   <= so_d;
            done_q <= done_d;
        end
    end

    assign b         = r_q;
    assign step      = s_q;
    assign shift_out = so_q;
    assign done      = done_q;

endmodule

// File: tb/tb_ari_rigs.sv
// Bench for ari_rigs: directed steps plus random traffic against a floor-division reference model.
module tb_ari_rigs;

    localparam int N = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              load, shift_en;
    logic signed [N:0] a, b;
    logic [$clog2(N+1)-1:0] step;
    logic              shift_out, done;

    logic              load1, sh1;
    logic signed [1:0] a1, b1;
    logic [0:0]        step1;
    logic              so1, done1;

    ari_rigs #(.N(N)) dut (
        .clk(clk), .rst(rst), .load(load), .shift_en(shift_en), .a(a),
        .b(b), .step(step), .shift_out(shift_out), .done(done)
    );

    ari_rigs #(.N(1)) dut1 (
        .clk(clk), .rst(rst), .load(load1), .shift_en(sh1), .a(a1),
        .b(b1), .step(step1), .shift_out(so1), .done(done1)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int m_a = 0, m_k = 0;
    int m1_a = 0, m1_k = 0;
    int exp_b[8]  = '{75, 37, 18, 9, 4, 2, 1, 0};
    int exp_so[8] = '{1, 1, 1, 0, 1, 0, 0, 1};

    // floor(v / 2^k), rounding toward negative infinity
    function automatic int fl(input int v, input int k);
        int d;
        d = 1 << k;
        if (v >= 0) return v / d;
        return -((-v + d - 1) / d);
    endfunction

    // bit lost by the k-th shift, i.e. LSB of floor(v / 2^(k-1))
    function automatic int lost_bit(input int v, input int k);
        if (k == 0) return 0;
        return fl(v, k - 1) & 1;
    endfunction

    task automatic chk(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".b"},         int'(b),         fl(m_a, m_k));
        chk({tag, ".step"},      int'(step),      m_k);
        chk({tag, ".shift_out"}, int'(shift_out), lost_bit(m_a, m_k));
        chk({tag, ".done"},      int'(done),      (m_k == N) ? 1 : 0);
    endtask

    task automatic check_all1(input string tag);
        chk({tag, ".b"},         int'(b1),    fl(m1_a, m1_k));
        chk({tag, ".step"},      int'(step1), m1_k);
        chk({tag, ".shift_out"}, int'(so1),   lost_bit(m1_a, m1_k));
        chk({tag, ".done"},      int'(done1), (m1_k == 1) ? 1 : 0);
    endtask

    task automatic cyc(input string tag, input logic ld, input logic sh, input int av);
        load     = ld;
        shift_en = sh;
        a        = av[N:0];
        @(posedge clk);
        #1;
        if (ld) begin
            m_a = av;
            m_k = 0;
        end else if (sh && m_k < N) begin
            m_k++;
        end
        check_all(tag);
    endtask

    task automatic cyc1(input string tag, input logic ld, input logic sh, input int av);
        load1 = ld;
        sh1   = sh;
        a1    = av[1:0];
        @(posedge clk);
        #1;
        if (ld) begin
            m1_a = av;
            m1_k = 0;
        end else if (sh && m1_k < 1) begin
            m1_k++;
        end
        check_all1(tag);
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; shift_en = 1'b0; a = '0;
        load1 = 1'b0; sh1 = 1'b0; a1 = '0;
        #12;
        check_all("reset");
        check_all1("reset1");
        @(negedge clk);
        rst = 1'b0;

        cyc("pos_load", 1'b1, 1'b0, 151);
        for (int i = 0; i < 8; i++) begin
            cyc("pos_shift", 1'b0, 1'b1, 0);
            chk("pos_const.b", int'(b), exp_b[i]);
            chk("pos_const.shift_out", int'(shift_out), exp_so[i]);
        end
        chk("pos_const.done", int'(done), 1);
        for (int i = 0; i < 3; i++) cyc("saturate", 1'b0, 1'b1, 0);

        cyc("neg_load", 1'b1, 1'b0, -256);
        for (int i = 0; i < 8; i++) cyc("neg_shift", 1'b0, 1'b1, 0);
        chk("neg_const.b", int'(b), -1);

        cyc("prio_load", 1'b1, 1'b0, 100);
        for (int i = 0; i < 3; i++) cyc("prio_shift", 1'b0, 1'b1, 0);
        cyc("prio_restart", 1'b1, 1'b1, -3);
        cyc("prio_after", 1'b0, 1'b1, 0);
        chk("prio_const.b", int'(b), -2);

        cyc("gap_load", 1'b1, 1'b0, -77);
        for (int i = 0; i < 10; i++) cyc("gap", 1'b0, (i % 2) == 0, 0);

        cyc("arst_load", 1'b1, 1'b0, 200);
        cyc("arst_shift", 1'b0, 1'b1, 0);
        cyc("arst_shift", 1'b0, 1'b1, 0);
        #2 rst = 1'b1;
        #1;
        m_a = 0; m_k = 0; m1_a = 0; m1_k = 0;
        check_all("arst_immediate");
        load = 1'b1; shift_en = 1'b1; a = 9'sd55;
        @(posedge clk);
        #1;
        check_all("arst_held");
        @(negedge clk);
        rst = 1'b0;
        cyc("arst_zero_shift", 1'b0, 1'b1, 0);

        for (int i = 0; i < 300; i++) begin
            cyc("rand", ($urandom % 8) == 0, $urandom_range(0, 1) == 1,
                int'($urandom_range(0, 511)) - 256);
        end

        cyc1("n1_load", 1'b1, 1'b0, -2);
        cyc1("n1_shift", 1'b0, 1'b1, 0);
        cyc1("n1_sat", 1'b0, 1'b1, 0);
        cyc1("n1_load_pos", 1'b1, 1'b0, 1);
        cyc1("n1_shift_pos", 1'b0, 1'b1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ari_rigs.md
# ari_rigs

Parameterised arithmetic right-shift register for signed operands. A signed word is loaded, then shifted right by one bit per enabled clock with sign extension, for at most N steps. The block is a stand-alone datapath primitive used by sequential arithmetic units such as serial dividers and scalers, which need a step-by-step signed shift with a step counter and a completion flag.

## Interface
- N, default 8: shift count limit; data width is N+1 bits, signed two's complement.
- clk  input  1  rising-edge clock for all state.
- rst  input  1  asynchronous, active-high reset.
- load  input  1  capture `a` into the shift register on this clock edge.
- shift_en  input  1  request one arithmetic right shift on this clock edge.
- a  input  N+1 (signed)  operand to load.
- b  output  N+1 (signed)  current register contents, registered.
- step  output  $clog2(N+1)  number of shifts performed since the last load, 0..N.
- shift_out  output  1  LSB shifted out by the most recent shift, registered.
- done  output  1  high when step == N.

## Operation
- State: data register R (N+1 bits), step counter S, shift_out flop, done flop.
- b = R, step = S; both are direct register outputs with no combinational path from inputs.
- Load (load=1): R <= a, S <= 0, shift_out <= 0, done <= 0. Load has priority over shift_en in the same cycle.
- Shift (load=0, shift_en=1, done=0): R <= {R[N], R[N:1]}, so the MSB is replicated. shift_out <= R[0]. S <= S+1. done <= (S+1 == N).
- Shift request while done=1: ignored. R, S, shift_out and done all hold. S never exceeds N and never wraps.
- Idle (load=0, shift_en=0): all state holds.
- Arithmetic: R after k shifts equals floor(a / 2^k), rounding toward negative infinity. A positive operand converges to 0. A negative operand converges to -1 (all ones).
- A shift on R=0 or R=-1 is legal. R is unchanged, but S still increments.
- N=1 is legal. done asserts after the first shift.

## Timing
- Reset (asynchronous assert, takes effect immediately): b=0, step=0, shift_out=0, done=0.
- Reset release is synchronous to the next clk edge. No operation occurs on the edge coincident with rst=1.
- Load latency: b reflects `a` one clock after the load edge.
- Shift latency: each shift is visible on b, step and shift_out one clock after the enabled edge. A full sequence takes N enabled cycles after load.
- done rises on the same edge that makes step == N. It stays high until the next load or reset.
- Reset mid-sequence: all outputs clear immediately. The partial shift result is lost. A new load is required.
- Load mid-sequence: restarts at step 0 with the new `a`. No residual shift is applied.
- No handshake on load or shift_en: every qualified edge is consumed, and no back-pressure exists.

## Test plan
- Reset: assert rst asynchronously mid-cycle. Required: b=0, step=0, done=0, shift_out=0 immediately, without waiting for a clock edge.
- Positive operand, N=8: load a=9'b0_1001_0111 (151), then 8 shifts. Required b sequence: 75, 37, 18, 9, 4, 2, 1, 0. Required shift_out sequence: 1,1,1,0,1,0,0,1. done=1 when step=8.
- Negative operand: load a=9'b1_0000_0000 (-256), then 8 shifts. Required b: -128, -64, -32, -16, -8, -4, -2, -1. shift_out=0 throughout.
- Saturation: after done=1, hold shift_en=1 for 3 more cycles. Required: b, step=8, shift_out and done are all unchanged.
- Priority and restart: at step 3, assert load=1 and shift_en=1 together with a=-3. Required on the next cycle: b=-3, step=0, done=0. One further shift gives b=-2, shift_out=1.
- Gaps: shift with shift_en toggling every other cycle. Required: step advances only on enabled edges, and b holds between them.
